// File: rtl/cargo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cargo_pkg
// Brief    : Class encodings, default thresholds and output FSM states
//            shared by the cargo classifier (optional CARGO_OVERWEIGHT_EN).
// Revision : 1.0
// ============================================================================
package cargo_pkg;

   localparam int W_DEF          = 4;
   localparam int LIGHT_MAX_DEF  = 3;
   localparam int MEDIUM_MAX_DEF = 6;
   localparam int HEAVY_MAX_DEF  = 12;
   localparam int CNT_W_DEF      = 8;
   localparam int STALL_MAX_DEF  = 15;

   // Class indices double as bit positions of the one-hot class vector
   localparam int CLS_EMPTY  = 0;
   localparam int CLS_LIGHT  = 1;
   localparam int CLS_MEDIUM = 2;
   localparam int CLS_HEAVY  = 3;
   localparam int CLS_OVER   = 4;

`ifdef CARGO_OVERWEIGHT_EN
   localparam int NUM_CLS = 5;
`else
   localparam int NUM_CLS = 4;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } out_state_t;

endpackage
`default_nettype wire

// File: rtl/cargo_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : cargo_sat_counter
// Brief    : Saturating tally; clr wins and seeds the count with load1.
// Revision : 1.0
// ============================================================================
module cargo_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             load1,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = load1 ? WIDTH'(1) : '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/cargo_classifier.sv
`default_nettype none
// ============================================================================
// Module   : cargo_classifier
// Brief    : Pipelined weight classifier with valid/ready handshake, saturating
//            per-class tallies and stall flag. CARGO_OVERWEIGHT_EN adds the
//            overweight class.
// Revision : 1.0
// ============================================================================
module cargo_classifier
   import cargo_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int LIGHT_MAX  = LIGHT_MAX_DEF,
   parameter int MEDIUM_MAX = MEDIUM_MAX_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int STALL_MAX  = STALL_MAX_DEF
`ifdef CARGO_OVERWEIGHT_EN
   ,parameter int HEAVY_MAX = HEAVY_MAX_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     weight,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             empty,
   output logic             light,
   output logic             medium_,
   output logic             heavy,
`ifdef CARGO_OVERWEIGHT_EN
   output logic             overweight,
   output logic [CNT_W-1:0] cnt_over,
`endif
   output logic [CNT_W-1:0] cnt_empty,
   output logic [CNT_W-1:0] cnt_light,
   output logic [CNT_W-1:0] cnt_medium,
   output logic [CNT_W-1:0] cnt_heavy,
   input  logic             clr,
   output logic             stall
);

   localparam int               WAIT_W   = $clog2(STALL_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STALL_MAX);
   localparam logic [W-1:0]     LIGHT_W  = W'(LIGHT_MAX);
   localparam logic [W-1:0]     MEDIUM_W = W'(MEDIUM_MAX);
`ifdef CARGO_OVERWEIGHT_EN
   localparam logic [W-1:0]     HEAVY_W  = W'(HEAVY_MAX);
`endif

   out_state_t          state_q;
   logic [NUM_CLS-1:0]  cls_q;
   logic [NUM_CLS-1:0]  cls_d;
   logic [WAIT_W-1:0]   wait_q;
   logic                accept;
   logic [CNT_W-1:0]    cnt_q [NUM_CLS];

   assign out_valid = (state_q == ST_FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_comb begin
      cls_d = '0;
      if (weight == '0) begin
         cls_d[CLS_EMPTY] = 1'b1;
      end else if (weight <= LIGHT_W) begin
         cls_d[CLS_LIGHT] = 1'b1;
      end else if (weight <= MEDIUM_W) begin
         cls_d[CLS_MEDIUM] = 1'b1;
`ifdef CARGO_OVERWEIGHT_EN
      end else if (weight <= HEAVY_W) begin
         cls_d[CLS_HEAVY] = 1'b1;
      end else begin
         cls_d[CLS_OVER] = 1'b1;
`else
      end else begin
         cls_d[CLS_HEAVY] = 1'b1;
`endif
      end
   end

   // In FULL an accept implies out_ready, so load and drain happen together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cls_q   <= '0;
         wait_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_FULL;
                  cls_q   <= cls_d;
               end
            end
            ST_FULL: begin
               if (accept) begin
                  cls_q <= cls_d;
               end else if (out_ready) begin
                  state_q <= ST_IDLE;
                  cls_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cls_q   <= '0;
            end
         endcase

         if (out_valid && !out_ready) begin
            if (wait_q != WAIT_SAT) begin
               wait_q <= wait_q + WAIT_W'(1);
            end
         end else begin
            wait_q <= '0;
         end
      end
   end

   assign stall = (wait_q == WAIT_SAT);

   for (genvar i = 0; i < NUM_CLS; i++) begin : g_cnt
      cargo_sat_counter #(
         .WIDTH (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (accept && cls_d[i]),
         .clr   (clr),
         .load1 (accept && cls_d[i]),
         .count (cnt_q[i])
      );
   end

   assign empty      = cls_q[CLS_EMPTY];
   assign light      = cls_q[CLS_LIGHT];
   assign medium_    = cls_q[CLS_MEDIUM];
   assign heavy      = cls_q[CLS_HEAVY];
   assign cnt_empty  = cnt_q[CLS_EMPTY];
   assign cnt_light  = cnt_q[CLS_LIGHT];
   assign cnt_medium = cnt_q[CLS_MEDIUM];
   assign cnt_heavy  = cnt_q[CLS_HEAVY];
`ifdef CARGO_OVERWEIGHT_EN
   assign overweight = cls_q[CLS_OVER];
   assign cnt_over   = cnt_q[CLS_OVER];
`endif

endmodule
`default_nettype wire
